cai_submit_fetch: RTL



---
 rtl/cai_pkg.sv | 6 +
 rtl/cai_ring_ptr.sv | 25 ++
 rtl/cai_submit_fetch.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cai_pkg.sv
// Shared CAI definitions: fetch FSM state encoding and the default descriptor stride.
package cai_pkg;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, ERR} cai_fetch_state_e;

    localparam int CAI_DESC_BYTES = 32;
endpackage

// File: rtl/cai_ring_ptr.sv
// Ring slot pointer with wrap-at-size; head_nxt lets the owner precompute addresses.
module cai_ring_ptr #(
    parameter int RING_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    input  logic [RING_W-1:0] size,
    output logic [RING_W-1:0] head,
    output logic [RING_W-1:0] head_nxt
);
    always_comb begin
        head_nxt = head;
        if (clear)
            head_nxt = '0;
        else if (advance)
            head_nxt = (head == size - 1'b1) ? '0 : head + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) head <= '0;
        else     head <= head_nxt;
    end
endmodule

// File: rtl/cai_submit_fetch.sv
// Submit-ring fetcher: counts doorbells, reads one descriptor at a time, and hands
// each one to the command decoder tagged with context and ring slot.
module cai_submit_fetch
    import cai_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int RING_W     = 32,
    parameter int CTX_W      = 16,
    parameter int DESC_W     = 256,
    parameter int DESC_BYTES = CAI_DESC_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] submit_base,
    input  logic [RING_W-1:0] submit_size,
    input  logic              submit_doorbell,
    input  logic [CTX_W-1:0]  context_sel,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_rsp_valid,
    input  logic [DESC_W-1:0] rd_rsp_data,
    input  logic              rd_rsp_err,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [DESC_W-1:0] desc_data,
    output logic [CTX_W-1:0]  desc_ctx,
    output logic [RING_W-1:0] desc_idx,
    output logic [RING_W-1:0] head,
    output logic [RING_W-1:0] pending,
    output logic              busy,
    output logic              err_fetch,
    output logic              err_overflow
);
    localparam int OFS_SH = $clog2(DESC_BYTES);

    cai_fetch_state_e  state, state_nxt;
    logic [ADDR_W-1:0] base_snap, base_use, addr_nxt;
    logic [RING_W-1:0] size_snap, head_nxt, pending_nxt;
    logic              go, clr, handoff, ovf, inc, rsp_take;

    assign go       = (state == IDLE) && enable && (pending != '0);
    assign clr      = (state == IDLE) && !enable;
    assign handoff  = (state == OUT) && desc_ready;
    assign rsp_take = (state == WAIT) && rd_rsp_valid;
    assign ovf      = submit_doorbell && ((pending == submit_size) || (submit_size == '0));
    assign inc      = submit_doorbell && !ovf;
    assign desc_idx = head;

    cai_ring_ptr #(.RING_W(RING_W)) u_head (
        .clk      (clk),
        .rst      (rst),
        .clear    (clr),
        .advance  (handoff),
        .size     (size_snap),
        .head     (head),
        .head_nxt (head_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (go) state_nxt = REQ;
            REQ:  if (rd_req_ready) state_nxt = WAIT;
            WAIT: if (rd_rsp_valid) state_nxt = rd_rsp_err ? ERR : OUT;
            OUT:  if (desc_ready) state_nxt = (enable && pending > 1) ? REQ : IDLE;
            ERR:  if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address is formed from next-cycle base/head so it is registered on REQ entry.
    always_comb begin
        base_use = go ? submit_base : base_snap;
        addr_nxt = base_use + (ADDR_W'(head_nxt) << OFS_SH);
    end

    always_comb begin
        pending_nxt = pending;
        if (inc && !handoff)
            pending_nxt = pending + 1'b1;
        else if (!inc && handoff)
            pending_nxt = pending - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            base_snap    <= '0;
            size_snap    <= '0;
            desc_ctx     <= '0;
            desc_data    <= '0;
            rd_req_addr  <= '0;
            rd_req_valid <= 1'b0;
            desc_valid   <= 1'b0;
            busy         <= 1'b0;
            pending      <= '0;
            err_fetch    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state        <= state_nxt;
            rd_req_valid <= (state_nxt == REQ);
            desc_valid   <= (state_nxt == OUT);
            busy         <= (state_nxt != IDLE);
            if (go) begin
                base_snap <= submit_base;
                size_snap <= submit_size;
                desc_ctx  <= context_sel;
            end
            if (state_nxt == REQ && state != REQ)
                rd_req_addr <= addr_nxt;
            if (rsp_take)
                desc_data <= rd_rsp_data;
            if (clr) begin
                pending      <= '0;
                err_fetch    <= 1'b0;
                err_overflow <= 1'b0;
            end else begin
                pending <= pending_nxt;
                if (ovf) err_overflow <= 1'b1;
                if (rsp_take && rd_rsp_err) err_fetch <= 1'b1;
            end
        end
    end
endmodule
